// File: rtl/fifo_uart_pkg.sv
`timescale 1ns/1ps
// Shared constants for the FIFO-fed UART transmitter: FSM state codes,
// frame geometry and the default bit period.
package fifo_uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int FRAME_BITS           = 10;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_POP   = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_START = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_STOP  = 3'd5;

    // The serial line is only driven by the bit timer in these states
    function automatic logic state_on_line(input logic [2:0] st);
        return (st == ST_START) || (st == ST_DATA) || (st == ST_STOP);
    endfunction

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
`timescale 1ns/1ps
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high and flags
// the last clock of every bit period.
module uart_bit_timer
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_done
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    logic [15:0] cnt_r;

    assign bit_done = run && (cnt_r == LAST_CNT);

    // Bit counter: held at zero when idle, wraps at the end of each period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 16'd0;
        end else if (!run) begin
            cnt_r <= 16'd0;
        end else if (cnt_r == LAST_CNT) begin
            cnt_r <= 16'd0;
        end else begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
`timescale 1ns/1ps
// FIFO-fed 8N1 UART transmitter. Pops one byte from an upstream FIFO,
// latches it the following cycle and shifts it out LSB first.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_dout,
    output logic        fifo_pop,
    output logic        txd,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    logic [2:0]  state_r;
    logic [2:0]  state_s;
    logic [7:0]  shreg_r;
    logic [7:0]  shreg_s;
    logic [2:0]  idx_r;
    logic [2:0]  idx_s;
    logic        txd_r;
    logic        txd_s;
    logic        busy_r;
    logic [15:0] frame_cnt_r;
    logic        frame_inc_s;
    logic        bit_done_s;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .run      (state_on_line(state_r)),
        .bit_done (bit_done_s)
    );

    // The read strobe is a pure state decode, so it lasts one cycle per byte
    assign fifo_pop  = (state_r == ST_POP);
    assign txd       = txd_r;
    assign busy      = busy_r;
    assign frame_cnt = frame_cnt_r;

    // Next-state, shift register and bit index logic
    always_comb begin
        state_s     = state_r;
        shreg_s     = shreg_r;
        idx_s       = idx_r;
        frame_inc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable && !fifo_empty) begin
                    state_s = ST_POP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_POP: begin
                state_s = ST_LATCH;
            end
            ST_LATCH: begin
                shreg_s = fifo_dout;
                state_s = ST_START;
            end
            ST_START: begin
                if (bit_done_s) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_done_s) begin
                    shreg_s = {1'b0, shreg_r[7:1]};
                    if (idx_r == 3'(DATA_BITS - 1)) begin
                        idx_s   = 3'd0;
                        state_s = ST_STOP;
                    end else begin
                        idx_s   = idx_r + 3'd1;
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (bit_done_s) begin
                    frame_inc_s = 1'b1;
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = 3'd0;
            end
        endcase
    end

    // Line level follows the next state so txd lines up with state_r
    always_comb begin
        txd_s = 1'b1;
        case (state_s)
            ST_START: txd_s = 1'b0;
            ST_DATA:  txd_s = shreg_s[0];
            default:  txd_s = 1'b1;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            shreg_r     <= 8'h00;
            idx_r       <= 3'd0;
            txd_r       <= 1'b1;
            busy_r      <= 1'b0;
            frame_cnt_r <= 16'h0000;
        end else begin
            state_r <= state_s;
            shreg_r <= shreg_s;
            idx_r   <= idx_s;
            txd_r   <= txd_s;
            busy_r  <= (state_s != ST_IDLE);
            if (frame_inc_s) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
`timescale 1ns/1ps
// Self-checking bench for fifo_uart_tx: a queue-backed FIFO model feeds the
// DUT, a serial decoder rebuilds each frame and compares it against the
// bytes queued as expected when the FIFO was loaded.
module tb_fifo_uart_tx;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_dout = 8'h00;
    logic        fifo_pop;
    logic        txd;
    logic        busy;
    logic [15:0] frame_cnt;

    logic [7:0]  fifo_q[$];
    logic [7:0]  exp_q[$];
    logic        hold_empty = 1'b0;
    int          pop_cnt = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    logic        mon_act = 1'b0;
    int          mon_c = 0;
    logic [9:0]  mon_bits = 10'd0;
    logic        mon_stable = 1'b1;
    int          gap_cnt = 0;
    int          last_gap = 0;

    fifo_uart_tx #(.CLKS_PER_BIT(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_pop   (fifo_pop),
        .txd        (txd),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // FIFO model: read data appears the cycle after the pop is sampled
    always @(posedge clk) begin
        if (fifo_pop) begin
            pop_cnt <= pop_cnt + 1;
            if (fifo_q.size() > 0) begin
                fifo_dout <= fifo_q.pop_front();
            end else begin
                fifo_dout <= 8'h00;
            end
        end
    end

    // Empty flag refreshed away from the DUT sampling edge
    always @(negedge clk) begin
        fifo_empty <= (fifo_q.size() == 0) || hold_empty;
    end

    // Serial decoder and scoreboard consumer
    initial begin
        forever begin
            @(negedge clk);
            if (fifo_pop) check("pop_nonempty", {31'd0, fifo_empty}, 32'd0);
            if (rst) begin
                mon_act = 1'b0;
                gap_cnt = 0;
            end else if (!mon_act) begin
                if (txd == 1'b0) begin
                    mon_act    = 1'b1;
                    mon_c      = 1;
                    mon_bits   = 10'd0;
                    mon_stable = 1'b1;
                    last_gap   = gap_cnt;
                end else begin
                    gap_cnt++;
                end
            end else begin
                if (mon_c % N == 0) mon_bits[mon_c / N] = txd;
                else if (txd !== mon_bits[mon_c / N]) mon_stable = 1'b0;
                if (mon_c == 10 * N - 1) begin
                    check("start_bit", {31'd0, mon_bits[0]}, 32'd0);
                    check("stop_bit", {31'd0, mon_bits[9]}, 32'd1);
                    check("bit_stable", {31'd0, mon_stable}, 32'd1);
                    if (exp_q.size() > 0) check("frame_byte", {24'd0, mon_bits[8:1]}, {24'd0, exp_q.pop_front()});
                    else check("unexpected_frame", {24'd0, mon_bits[8:1]}, 32'hFFFF_FFFF);
                    mon_act = 1'b0;
                    gap_cnt = 0;
                end else begin
                    mon_c++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic wait_quiet(input int max_cyc);
        int n;
        n = 0;
        tick(4);
        while (!(busy == 1'b0 && mon_act == 1'b0 && (fifo_q.size() == 0 || enable == 1'b0)) && n < max_cyc) begin
            tick(1);
            n++;
        end
        check("wait_quiet", 32'(n < max_cyc), 32'd1);
        tick(2);
    endtask

    initial begin
        int pops_before;

        // Reset held with a non-empty FIFO and enable high
        push(8'hA5);
        tick(1);
        for (int i = 0; i < 8; i++) begin
            check("rst_txd", {31'd0, txd}, 32'd1);
            check("rst_pop", {31'd0, fifo_pop}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_cnt", {16'd0, frame_cnt}, 32'd0);
            tick(1);
        end
        hold_empty = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(5);
        check("empty_hold_busy", {31'd0, busy}, 32'd0);
        check("empty_hold_pops", pop_cnt, 32'd0);

        // Single byte 0xA5 with latency check from the empty flag dropping
        hold_empty = 1'b0;
        tick(1);
        check("lat_pop", {31'd0, fifo_pop}, 32'd1);
        check("lat_txd0", {31'd0, txd}, 32'd1);
        tick(1);
        check("lat_pop_once", {31'd0, fifo_pop}, 32'd0);
        check("lat_txd1", {31'd0, txd}, 32'd1);
        check("lat_busy", {31'd0, busy}, 32'd1);
        tick(1);
        check("lat_start", {31'd0, txd}, 32'd0);
        wait_quiet(200);
        check("a5_cnt", {16'd0, frame_cnt}, 32'd1);
        check("a5_pops", pop_cnt, 32'd1);

        // Back-to-back 0x11, 0x22
        push(8'h11);
        push(8'h22);
        wait_quiet(300);
        check("b2b_gap", last_gap, 32'd3);
        check("b2b_cnt", {16'd0, frame_cnt}, 32'd3);
        check("b2b_pops", pop_cnt, 32'd3);

        // Enable dropped during DATA of 0x33 with 0x44 queued
        push(8'h33);
        push(8'h44);
        tick(12);
        enable = 1'b0;
        wait_quiet(200);
        check("en_cnt", {16'd0, frame_cnt}, 32'd4);
        pops_before = pop_cnt;
        tick(30);
        check("en_no_pop", pop_cnt, pops_before);
        check("en_idle_busy", {31'd0, busy}, 32'd0);
        check("en_idle_txd", {31'd0, txd}, 32'd1);
        check("en_queued", fifo_q.size(), 32'd1);
        enable = 1'b1;
        wait_quiet(200);
        check("en_cnt2", {16'd0, frame_cnt}, 32'd5);
        check("en_pops2", pop_cnt, pops_before + 1);

        // Reset pulsed during DATA of 0x55 with 0x66 queued
        push(8'h55);
        push(8'h66);
        tick(14);
        check("mid_in_frame", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_txd", {31'd0, txd}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_pop", {31'd0, fifo_pop}, 32'd0);
        check("mid_rst_cnt", {16'd0, frame_cnt}, 32'd0);
        exp_q.delete(0);
        tick(3);
        check("mid_cnt_held", {16'd0, frame_cnt}, 32'd0);
        rst = 1'b0;
        pops_before = pop_cnt;
        tick(1);
        check("mid_fresh_pop", {31'd0, fifo_pop}, 32'd1);
        wait_quiet(200);
        check("mid_cnt_after", {16'd0, frame_cnt}, 32'd1);
        check("mid_pops", pop_cnt, pops_before + 1);

        // Empty FIFO for 100 clocks
        for (int i = 0; i < 100; i++) begin
            tick(1);
            check("empty_pop", {31'd0, fifo_pop}, 32'd0);
            check("empty_txd", {31'd0, txd}, 32'd1);
            check("empty_busy", {31'd0, busy}, 32'd0);
        end
        check("exp_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clocks per serial bit; legal range 2..65535.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 enable  input  1  permits fetching new bytes from the upstream FIFO.
REQ-005 fifo_empty  input  1  upstream FIFO empty flag.
REQ-006 fifo_dout  input  8  upstream FIFO read data, valid the cycle after fifo_pop is sampled.
REQ-007 fifo_pop  output  1  one-cycle read strobe to the upstream FIFO.
REQ-008 txd  output  1  serial line, 8N1, LSB first, idle high.
REQ-009 busy  output  1  high while a byte is being fetched or transmitted.
REQ-010 frame_cnt  output  16  count of completed frames.

Function
REQ-011 The FSM SHALL have states IDLE, POP, LATCH, START, DATA, STOP.
REQ-012 IDLE: if enable=1 and fifo_empty=0 at a rising edge, go to POP; otherwise remain in IDLE.
REQ-013 fifo_pop SHALL be a decode of state==POP, so it is high for exactly one cycle per byte.
REQ-014 POP SHALL go to LATCH unconditionally.
REQ-015 LATCH SHALL capture fifo_dout into an 8-bit shift register and go to START.
REQ-016 txd SHALL be a registered output: 0 in START, the shift register LSB in DATA, and 1 in all other states.
REQ-017 START, each of the 8 DATA bits, and STOP SHALL each last exactly CLKS_PER_BIT clocks, timed by a bit counter running 0..CLKS_PER_BIT-1.
REQ-018 DATA SHALL shift right once per bit period, then go to STOP after the 8th bit.
REQ-019 Latency: with fifo_empty sampled low in IDLE at edge E, txd SHALL go low from edge E+2.
REQ-020 Each frame SHALL be 10*CLKS_PER_BIT clocks long.
REQ-021 At the end of STOP, frame_cnt SHALL increment and the FSM SHALL return to IDLE.
REQ-022 frame_cnt SHALL wrap from 0xFFFF to 0x0000.
REQ-023 Back-to-back frames: with the FIFO non-empty, txd SHALL stay high for exactly 3 clocks after the stop bit before the next start bit.
REQ-024 busy SHALL be high in POP, LATCH, START, DATA and STOP, and low in IDLE.
REQ-025 When enable falls mid-frame, the current frame SHALL complete normally, and no further pop SHALL occur while enable=0.
REQ-026 fifo_empty SHALL be ignored in every state except IDLE.
REQ-027 fifo_dout SHALL be ignored in every state except LATCH.
REQ-028 The block SHALL never pop the FIFO while fifo_empty=1.

Reset
REQ-029 When rst asserts, outputs SHALL take their reset values immediately: txd=1, fifo_pop=0, busy=0, frame_cnt=0.
REQ-030 Reset SHALL also clear the state to IDLE, the bit counter to 0, the bit index to 0 and the shift register to 0x00.
REQ-031 A frame interrupted by reset SHALL be discarded without being counted.
REQ-032 After rst deasserts, the first action SHALL be a fresh pop of the next FIFO byte.

Structure
REQ-033 A shared package fifo_uart_pkg SHALL hold the state enumeration, FRAME_BITS=10, DATA_BITS=8 and the default CLKS_PER_BIT.
REQ-034 Bit timing SHALL be a sub-module uart_bit_timer (inputs clk, rst, run; output bit_done pulse on the last clock of each bit period), instantiated once.

Verification (CLKS_PER_BIT=4)
REQ-035 Reset: hold rst=1 with fifo_empty=0 and enable=1 -> txd=1, fifo_pop=0, busy=0, frame_cnt=0 for the whole reset period.
REQ-036 Single byte 0xA5 -> one fifo_pop pulse; txd sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks; start bit 2 edges after empty deasserts; frame_cnt=1.
REQ-037 Back-to-back 0x11 then 0x22 -> two pops; txd high for exactly 3 clocks after the first stop bit; second frame decodes 0x22; frame_cnt=2.
REQ-038 Enable drop: enable=0 during DATA of 0x33, with 0x44 queued -> 0x33 frame completes; no pop while enable=0; 0x44 is sent after enable=1.
REQ-039 Reset mid-frame: rst pulsed during DATA of 0x55, with 0x66 queued -> txd=1 and busy=0 immediately; frame_cnt stays 0; after release 0x66 is popped and sent.
REQ-040 Empty FIFO: fifo_empty=1 for 100 clocks -> fifo_pop never asserts, txd stays 1, busy stays 0.
